// File: rtl/tx_pkg.sv
// tx_pkg: shared constants for the QPSK test transmitter (RRC table, PRBS taps, seeds, saturation).
package tx_pkg;
  localparam int DEF_OS = 4;
  localparam int DEF_NTAPS = 24;
  localparam int DEF_COEF_W = 16;
  localparam logic [8:0] DEF_SEED_I = 9'h1AA;
  localparam logic [8:0] DEF_SEED_Q = 9'h1FE;
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;
  // RRC, rolloff 0.5, OS=4, centred between taps 11 and 12, S(16,14) round-to-nearest
  localparam logic signed [DEF_COEF_W-1:0] RRC_H [DEF_NTAPS] = '{
    -16'sd125, -16'sd323, -16'sd38, 16'sd536, 16'sd622, -16'sd399,
    -16'sd2039, -16'sd2546, -16'sd25, 16'sd5852, 16'sd13009, 16'sd17933,
    16'sd17933, 16'sd13009, 16'sd5852, -16'sd25, -16'sd2546, -16'sd2039,
    -16'sd399, 16'sd622, 16'sd536, -16'sd38, -16'sd323, -16'sd125
  };
endpackage

// File: rtl/tx_branch.sv
// tx_branch: one rail -- PRBS9, +/-1 mapper, zero-stuffed delay line, multiplier-free FIR, saturation.
// TX_FILTER_BYPASS_EN replaces the FIR with x[n]*16384.
module tx_branch
  import tx_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter logic [8:0] SEED = DEF_SEED_I,
  parameter logic signed [COEF_W-1:0] H [NTAPS] = RRC_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sym,
  output logic signed [15:0] o_sample
);
  logic [8:0] r_lfsr;
  logic w_bit;
  assign w_bit = r_lfsr[PRBS_TAP_HI];
  always_ff @(posedge clk or posedge reset)
    if (reset) r_lfsr <= SEED;
    else if (i_sym) r_lfsr <= {r_lfsr[7:0], r_lfsr[PRBS_TAP_HI] ^ r_lfsr[PRBS_TAP_LO]};
`ifdef TX_FILTER_BYPASS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) o_sample <= '0;
    else o_sample <= i_sym ? (w_bit ? -16'sd16384 : 16'sd16384) : '0;
`else
  localparam int ACC_W = COEF_W + 6;
  logic [NTAPS-2:0] r_nz, r_neg;
  logic [NTAPS-1:0] w_nz, w_neg;
  logic signed [ACC_W-1:0] w_acc;
  // tap 0 is the current sample, so y[n] lands in the output register on edge n
  assign w_nz = {r_nz, i_sym};
  assign w_neg = {r_neg, w_bit};
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NTAPS; k++)
      if (w_nz[k]) w_acc = w_neg[k] ? w_acc - ACC_W'(H[k]) : w_acc + ACC_W'(H[k]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_nz <= '0;
      r_neg <= '0;
      o_sample <= '0;
    end else begin
      r_nz <= w_nz[NTAPS-2:0];
      r_neg <= w_neg[NTAPS-2:0];
      o_sample <= w_acc > ACC_W'(SAT_MAX) ? 16'sh7fff :
                  w_acc < ACC_W'(SAT_MIN) ? 16'sh8000 : w_acc[15:0];
    end
`endif
endmodule

// File: rtl/tx_top.sv
// tx_top: QPSK baseband test source -- shared symbol phase counter driving I and Q branches.
// Optional TX_FILTER_BYPASS_EN bypasses the RRC filter in both branches.
module tx_top
  import tx_pkg::*;
#(
  parameter int OS = DEF_OS,
  parameter int NTAPS = DEF_NTAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter logic [8:0] SEED_I = DEF_SEED_I,
  parameter logic [8:0] SEED_Q = DEF_SEED_Q,
  parameter logic signed [COEF_W-1:0] H [NTAPS] = RRC_H
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [15:0] sI_out,
  output logic signed [15:0] sQ_out
);
  localparam int PW = $clog2(OS);
  logic [PW-1:0] r_phase;
  logic w_sym;
  assign w_sym = r_phase == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_phase <= '0;
    else r_phase <= (r_phase == PW'(OS - 1)) ? '0 : r_phase + 1'b1;
  tx_branch #(.NTAPS(NTAPS), .COEF_W(COEF_W), .SEED(SEED_I), .H(H)) u_i (
    .clk(clk), .reset(reset), .i_sym(w_sym), .o_sample(sI_out)
  );
  tx_branch #(.NTAPS(NTAPS), .COEF_W(COEF_W), .SEED(SEED_Q), .H(H)) u_q (
    .clk(clk), .reset(reset), .i_sym(w_sym), .o_sample(sQ_out)
  );
endmodule

// File: tb/tb_tx_top.sv
// tb_tx_top: checks tx_top against a symbol-level reference (PRBS recurrence + FIR convolution sum),
// with randomized mid-stream asynchronous resets.
module tb_tx_top;
  import tx_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [15:0] sI_out, sQ_out;
  int checks = 0;
  int failures = 0;
  int cur_n = 0;
  bit bi [1024];
  bit bq [1024];
  tx_top dut (.clk(clk), .reset(reset), .sI_out(sI_out), .sQ_out(sQ_out));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0d exp=%0d", tag, cur_n, got, exp);
    end
  endtask
  // y[n] = sum_k h[k] x[n-k], x nonzero only every OS-th sample, a = +1 for bit 0 and -1 for bit 1
  function automatic int model_y(input int n, input bit q);
    int acc;
    bit b;
    acc = 0;
`ifdef TX_FILTER_BYPASS_EN
    b = q ? bq[(n / DEF_OS) % 1024] : bi[(n / DEF_OS) % 1024];
    acc = (n % DEF_OS == 0) ? (b ? -16384 : 16384) : 0;
`else
    for (int k = 0; k < DEF_NTAPS; k++) begin
      int m;
      m = n - k;
      if (m >= 0 && m % DEF_OS == 0) begin
        b = q ? bq[m / DEF_OS] : bi[m / DEF_OS];
        acc += b ? -int'(RRC_H[k]) : int'(RRC_H[k]);
      end
    end
`endif
    return acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
  endfunction
  task automatic run_stream(input int len);
    for (int n = 0; n < len; n++) begin
      cur_n = n;
      @(posedge clk);
      #1;
      chk("stream_I", sI_out, model_y(n, 1'b0));
      chk("stream_Q", sQ_out, model_y(n, 1'b1));
    end
  endtask
  task automatic async_reset(input int hold);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_clear_I", sI_out, 0);
    chk("async_clear_Q", sQ_out, 0);
    repeat (hold) @(posedge clk);
    #1;
    chk("held_I", sI_out, 0);
    chk("held_Q", sQ_out, 0);
    @(negedge clk) reset = 1'b0;
  endtask
  initial begin
    logic [8:0] si, sq;
    si = DEF_SEED_I;
    sq = DEF_SEED_Q;
    // output sequence obeys c[j+9] = c[j] ^ c[j+4], first nine outputs are seed bits 8 down to 0
    for (int i = 0; i < 9; i++) begin
      bi[i] = si[8-i];
      bq[i] = sq[8-i];
    end
    for (int i = 9; i < 1024; i++) begin
      bi[i] = bi[i-9] ^ bi[i-5];
      bq[i] = bq[i-9] ^ bq[i-5];
    end
    repeat (10) begin
      @(negedge clk);
      chk("reset_I", sI_out, 0);
      chk("reset_Q", sQ_out, 0);
    end
    reset = 1'b0;
    run_stream(2100);
    async_reset($urandom_range(1, 4));
    run_stream($urandom_range(300, 900));
    async_reset(3);
    run_stream(2100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tx_top.md
Name: tx_top

Overview:
Self-contained baseband QPSK transmitter test source.
- Two PRBS9 generators (I and Q) each produce one bit per symbol.
- Each bit is mapped to ±1, zero-stuffed upsampled by OS, and shaped by an NTAPS-tap root-raised-cosine FIR.
- Outputs are 16-bit signed I/Q samples, one per clock.
- Top of the TX chain; feeds the channel/RX model and is checked sample-exactly against the team's Python golden model ("hex_I hex_Q" per line, one line per clock).

Parameters:
OS, 4, oversampling factor (samples per symbol); must be ≥ 2.
NTAPS, 24, FIR length (6 symbols span at OS=4).
COEF_W, 16, coefficient width, signed S(16,14).
SEED_I, 9'h1AA, PRBS9 reset state for the I branch; must be nonzero.
SEED_Q, 9'h1FE, PRBS9 reset state for the Q branch; must be nonzero.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
sI_out  output  16  signed in-phase sample, registered.
sQ_out  output  16  signed quadrature sample, registered.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
Reset:
- While reset=1, all registers are cleared immediately, without waiting for clk:
  - LFSRs load SEED_I / SEED_Q.
  - Phase counter = 0.
  - Delay lines = 0.
  - sI_out = sQ_out = 0.
- Reset asserted mid-stream aborts the stream; the sequence restarts identically after release.

Cycle indexing: edge n=0 is the first rising edge with reset low.

PRBS9:
- State s[8:0]; output bit b = s[8].
- Feedback fb = s[8]^s[4] (x^9+x^5+1).
- Advance rule: s <= {s[7:0], fb}, only on symbol edges.
- Period is 511 symbols.

Symbol timing:
- Phase counter p counts 0..OS-1 and wraps.
- Edge n is a symbol edge when p==0, i.e. n mod OS == 0.

Mapping:
- bit 0 -> +1, bit 1 -> -1.
- Upsampled input x[n] = a[n/OS] if n mod OS == 0, else 0.
- x[m] = 0 for m < 0, so the delay line starts empty.

FIR:
- y[n] = Σ_{k=0}^{NTAPS-1} h[k]·x[n-k].
- No multipliers: each term is +h[k], -h[k] or 0.
- Accumulate in ≥ COEF_W+5 bits.
- Saturate to [-32768, 32767].

Output and latency:
- The value present after edge n is y[n] for both branches.
- This is one registered stage; the first nonzero output appears after edge 0.
- Output sequence period is 511·OS clocks.

Coefficients:
- Symmetric RRC, rolloff 0.5, h[k] = h[NTAPS-1-k].
- Quantized S(16,14), round-to-nearest; fixed table in the package.
- The same h is used by the Python model.

I and Q branches are identical except for their seeds. No handshake: a sample is produced every clock.

Optional Feature:
Macro: TX_FILTER_BYPASS_EN.
- Defined: the FIR is removed. sI_out/sQ_out = x[n]·16384, i.e. +16384 / -16384 on symbol edges and 0 otherwise. Same single-register latency.
- Undefined: normal RRC output as above.

Decomposition:
- Package tx_pkg holds:
  - OS, NTAPS, COEF_W default values.
  - The RRC coefficient table h[0..NTAPS-1].
  - PRBS tap positions and default seeds.
  - The saturation bounds.
- One natural sub-module, tx_branch: PRBS9, mapper, zero-stuff delay line, FIR and saturation for one rail, with its seed as a parameter.
- tx_top instantiates tx_branch twice and owns the shared phase counter.

Test Plan:
1. Reset held 100 ns -> sI_out = sQ_out = 0 throughout. Asserting reset between clock edges clears the outputs without waiting for an edge.
2. Release reset with the TX_FILTER_BYPASS_EN build:
   - After edge 0: sI = -16384, sQ = -16384 (both seeds have MSB 1).
   - Edges 1..3: 0.
   - Edge 4: I symbol from bit s[7] of 1AA = 1 -> -16384.
3. Normal build -> after edge 0, sI = sQ = -h[0]; after edge 4, sI = a0·h[4] + a1·h[0]. The full stream matches the Python golden file sample-exactly for ≥ 2044 clocks with 0 mismatches.
4. Periodicity -> y[n] == y[n+2044] for all n ≥ NTAPS (OS=4).
5. Mid-stream reset at n=777 for 3 cycles -> the post-release stream is identical to the first 2044 samples after the initial reset.
6. Saturation: alternate coefficient table with all h = 8000 (NTAPS=24, OS=1, all symbols -1) -> outputs clamp at -32768 and never wrap positive.
